// File: rtl/exu_branch_flushctl_pkg.sv
// Shared EXU definitions for the commit-stage branch flush controller:
// widths, state encoding and constants used by the controller and its stats block.
package exu_branch_flushctl_pkg;

    localparam int EXU_PC_SIZE = 32;
    localparam int EXU_XLEN    = 32;

    localparam int DRAIN_CNT_W = 4;
    localparam int PC_INCR     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } flush_state_e;

endpackage

// File: rtl/exu_branch_flushctl_stat.sv
// Saturating statistics counters for committed branches and mispredicts.
module exu_branch_stat #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bjp_inc_i,
    input  logic             mis_inc_i,
    output logic [CNT_W-1:0] bjp_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o
);

    logic [CNT_W-1:0] bjp_cnt_q;
    logic [CNT_W-1:0] mis_cnt_q;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bjp_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (bjp_inc_i && (bjp_cnt_q != '1)) begin
                bjp_cnt_q <= bjp_cnt_q + 1'b1;
            end
            if (mis_inc_i && (mis_cnt_q != '1)) begin
                mis_cnt_q <= mis_cnt_q + 1'b1;
            end
        end
    end

    assign bjp_cnt_o = bjp_cnt_q;
    assign mis_cnt_o = mis_cnt_q;

endmodule

// File: rtl/exu_branch_flushctl.sv
// Commit-stage branch resolution: detects mispredicts, sequences the IFU
// redirect handshake, blocks commit for a drain window and trains the BPU.
module exu_branch_flushctl
    import exu_branch_flushctl_pkg::*;
#(
    parameter int PC_W      = EXU_PC_SIZE,
    parameter int IMM_W     = EXU_XLEN,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmt_i_valid,
    output logic             cmt_i_ready,
    input  logic             cmt_i_bjp,
    input  logic             cmt_i_bjp_prdt,
    input  logic             cmt_i_bjp_rslv,
    input  logic [PC_W-1:0]  cmt_i_pc,
    input  logic [IMM_W-1:0] cmt_i_imm,
    input  logic             cmt_i_kill,
    output logic             flush_o_valid,
    input  logic             flush_o_ready,
    output logic [PC_W-1:0]  flush_o_pc,
    output logic             bpu_upd_valid,
    output logic [PC_W-1:0]  bpu_upd_pc,
    output logic             bpu_upd_taken,
    output logic [CNT_W-1:0] stat_bjp_cnt,
    output logic [CNT_W-1:0] stat_mis_cnt
);

    flush_state_e           state_q;
    logic                   flush_valid_q;
    logic [PC_W-1:0]        flush_pc_q;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q;
    logic                   bpu_valid_q;
    logic [PC_W-1:0]        bpu_pc_q;
    logic                   bpu_taken_q;

    logic                   cmt_acc;
    logic                   bjp_acc;
    logic                   mispredict;
    logic [PC_W-1:0]        target_d;

    assign cmt_i_ready = (state_q == ST_IDLE) && !cmt_i_kill;
    assign cmt_acc     = cmt_i_valid && cmt_i_ready;
    assign bjp_acc     = cmt_acc && cmt_i_bjp;
    assign mispredict  = bjp_acc && (cmt_i_bjp_prdt != cmt_i_bjp_rslv);

    // Only the low PC_W bits of the offset matter; the sum wraps silently.
    assign target_d = cmt_i_bjp_rslv ? (cmt_i_pc + cmt_i_imm[PC_W-1:0])
                                     : (cmt_i_pc + PC_W'(PC_INCR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            flush_valid_q <= 1'b0;
            flush_pc_q    <= '0;
            drain_cnt_q   <= '0;
        end else if (cmt_i_kill) begin
            // An exception flush overrides everything, including a same-cycle handshake.
            state_q       <= ST_IDLE;
            flush_valid_q <= 1'b0;
            drain_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mispredict) begin
                        state_q       <= ST_FLUSH;
                        flush_valid_q <= 1'b1;
                        flush_pc_q    <= target_d;
                    end
                end
                ST_FLUSH: begin
                    if (flush_o_ready) begin
                        flush_valid_q <= 1'b0;
                        if (DRAIN_CYC > 0) begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= DRAIN_CNT_W'(DRAIN_CYC - 1);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    flush_valid_q <= 1'b0;
                    drain_cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bpu_valid_q <= 1'b0;
            bpu_pc_q    <= '0;
            bpu_taken_q <= 1'b0;
        end else begin
            bpu_valid_q <= bjp_acc;
            if (bjp_acc) begin
                bpu_pc_q    <= cmt_i_pc;
                bpu_taken_q <= cmt_i_bjp_rslv;
            end
        end
    end

    exu_branch_stat #(
        .CNT_W (CNT_W)
    ) u_stat (
        .clk       (clk),
        .rst       (rst),
        .bjp_inc_i (bjp_acc),
        .mis_inc_i (mispredict),
        .bjp_cnt_o (stat_bjp_cnt),
        .mis_cnt_o (stat_mis_cnt)
    );

    assign flush_o_valid = flush_valid_q;
    assign flush_o_pc    = flush_pc_q;
    assign bpu_upd_valid = bpu_valid_q;
    assign bpu_upd_pc    = bpu_pc_q;
    assign bpu_upd_taken = bpu_taken_q;

endmodule

// File: doc/exu_branch_flushctl.md
# exu_branch_flushctl

Commit-stage branch resolution controller. Sits alongside the commit branch slave in the EXU. For each committed branch/jump it:
- compares the predicted direction with the resolved direction;
- on a mispredict, sequences a redirect-flush handshake to the IFU, then holds off commit for a drain window.

It also emits a one-cycle BPU training update per committed branch and keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- PC_W, `PC_SIZE: program-counter width.
- IMM_W, `XLEN: immediate width. The immediate is truncated to PC_W bits before the add.
- DRAIN_CYC, 2: cycles commit stays blocked after a flush is accepted. Range 0..15.
- CNT_W, 32: width of each statistics counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- cmt_i_valid  input  1  commit slot holds an instruction.
- cmt_i_ready  output  1  controller accepts the commit slot.
- cmt_i_bjp  input  1  committed instruction is a branch or jump.
- cmt_i_bjp_prdt  input  1  predicted taken.
- cmt_i_bjp_rslv  input  1  resolved taken.
- cmt_i_pc  input  PC_W  PC of the committed instruction.
- cmt_i_imm  input  IMM_W  branch offset.
- cmt_i_kill  input  1  higher-priority (exception) flush; aborts any branch flush.
- flush_o_valid  output  1  redirect request to the IFU.
- flush_o_ready  input  1  IFU accepts the redirect.
- flush_o_pc  output  PC_W  redirect target.
- bpu_upd_valid  output  1  one-cycle training pulse.
- bpu_upd_pc  output  PC_W  PC of the trained branch.
- bpu_upd_taken  output  1  resolved direction.
- stat_bjp_cnt  output  CNT_W  count of committed branches, saturating.
- stat_mis_cnt  output  CNT_W  count of mispredicts, saturating.

## Operation
- Commit handshake: a commit is accepted on cmt_i_valid & cmt_i_ready, with cmt_i_ready = (state==IDLE) & ~cmt_i_kill.
- Mispredict condition: accepted & cmt_i_bjp & (cmt_i_bjp_prdt != cmt_i_bjp_rslv).
- Target computation:
  - resolved taken: target = cmt_i_pc + imm[PC_W-1:0];
  - resolved not-taken: target = cmt_i_pc + 4;
  - arithmetic is modulo 2^PC_W, and wrap-around is not flagged.
- FSM states:
  - IDLE: a mispredict goes to FLUSH, capturing the target into flush_o_pc.
  - FLUSH: flush_o_valid=1. flush_o_pc and flush_o_valid are held stable until flush_o_ready. On the handshake, go to DRAIN if DRAIN_CYC>0, otherwise to IDLE.
  - DRAIN: a 4-bit counter loads DRAIN_CYC-1 on entry. The state returns to IDLE on the cycle the counter reads 0.
- cmt_i_kill, in any state:
  - next state is IDLE;
  - flush_o_valid deasserts next cycle;
  - the drain counter clears;
  - in IDLE the same-cycle commit is not accepted, because ready is forced low.
- Kill versus ready in the same FLUSH cycle: kill takes priority. The handshake is still considered done by the IFU; the controller returns to IDLE, skipping DRAIN.
- BPU update: registered, asserted the cycle after every accepted commit with cmt_i_bjp=1, whether or not it mispredicted. Non-branch commits produce no pulse.
- Statistics:
  - stat_bjp_cnt increments per accepted branch;
  - stat_mis_cnt increments per mispredict;
  - both saturate at all-ones and never wrap.

## Timing
- Reset values:
  - state IDLE;
  - cmt_i_ready=1 (combinational, follows state);
  - flush_o_valid=0, flush_o_pc=0;
  - bpu_upd_valid=0, bpu_upd_pc=0, bpu_upd_taken=0;
  - both stat counters 0.
- Reset asserted mid-FLUSH drops flush_o_valid asynchronously.
- Latency: a mispredict accepted in cycle N gives flush_o_valid=1 in cycle N+1.
- Minimum stall:
  - with an IFU that is immediately ready, cmt_i_ready is low for 1+DRAIN_CYC cycles, from N+1 through N+1+DRAIN_CYC;
  - cmt_i_ready is high again at N+2+DRAIN_CYC.
- flush_o_ready held low: stays in FLUSH indefinitely, with outputs unchanged.
- bpu_upd_valid: exactly one cycle wide, at N+1.

## Structure
- FSM state encoding, DRAIN counter width, and the +4 increment constant: in the shared EXU package/defines alongside `PC_SIZE/`XLEN.
- One sub-module: exu_branch_stat, holding the two saturating counters with increment enables. The FSM, target adder and BPU register stay in the top module.

## Test plan
- Correct prediction: pc=0x80000000, prdt=1, rslv=1, imm=0x10 -> bpu_upd_valid pulse with taken=1. No flush; cmt_i_ready stays 1; stat_bjp_cnt=1, stat_mis_cnt=0.
- Mispredict not-taken→taken: pc=0x80000100, imm=0xFFFFFFF0, flush_o_ready=1 -> flush_o_pc=0x800000F0 at N+1. cmt_i_ready low N+1..N+3 with DRAIN_CYC=2; stat_mis_cnt=1.
- Mispredict taken→not-taken, wrap: pc=0xFFFFFFFC -> flush_o_pc=0x00000000.
- IFU backpressure: flush_o_ready low for 5 cycles -> flush_o_valid and flush_o_pc stable all 5 cycles; DRAIN starts after the handshake.
- Kill: cmt_i_kill asserted in FLUSH cycle 2 with flush_o_ready=0 -> flush_o_valid=0 next cycle, state IDLE, no DRAIN. Kill with cmt_i_valid in IDLE -> cmt_i_ready=0 and the commit is not counted.
- Saturation and reset: preload counters to all-ones via repeated mispredicts (CNT_W=4 in the bench) -> both hold at 0xF. Async rst low mid-DRAIN -> all outputs return to their reset values immediately.
